// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid word 0 (ID) and word 1 (timestamp) after reset and
// compares both against build-time values, raising done plus id_ok/ts_ok/timeout.
// Latency: done after the 4th clock edge following reset release with no stalls.
// Backpressure: avm_waitrequest stalls each read with address/read held stable;
// a read stalled beyond TIMEOUT_CYCLES ends the check with timeout=1.
// Optional feature: define SYSID_CHECKER_RECHECK_EN to re-run the check every
// RECHECK_PERIOD cycles while in DONE.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               pulse in DONE re-runs the check
//   avm_address/read    Avalon-MM master request (0 = ID, 1 = timestamp)
//   avm_readdata        read data, valid when read=1 and waitrequest=0
//   avm_waitrequest     slave stall
//   id_value/ts_value   captured words
//   busy/done           check in progress / finished
//   id_ok/ts_ok/timeout result flags
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1458169385,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_PERIOD = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [2:0]  state;
  logic        auto_go;
  logic [15:0] stall_cnt;
`ifdef SYSID_CHECKER_RECHECK_EN
  localparam logic [31:0] RECHECK_LAST = 32'(RECHECK_PERIOD - 1);
  logic [31:0] recheck_cnt;
`endif

  // Request outputs decode straight from state, so they are stable for the
  // whole stall and drop to 0 the instant reset asserts.
  assign avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
  assign avm_address = (state == S_RD_TS);
  assign busy        = avm_read || (state == S_CMP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      auto_go   <= 1'b1;
      stall_cnt <= 16'd0;
      id_value  <= 32'd0;
      ts_value  <= 32'd0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
`ifdef SYSID_CHECKER_RECHECK_EN
      recheck_cnt <= 32'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (auto_go) begin
            auto_go   <= 1'b0;
            stall_cnt <= 16'd0;
            state     <= S_RD_ID;
          end
        end

        S_RD_ID, S_RD_TS: begin
          if (!avm_waitrequest) begin
            stall_cnt <= 16'd0;
            if (state == S_RD_ID) begin
              id_value <= avm_readdata;
              state    <= S_RD_TS;
            end else begin
              ts_value <= avm_readdata;
              state    <= S_CMP;
            end
          end else if (stall_cnt == TIMEOUT_LIM) begin
            // Abandon the check; the word not yet read keeps its old value.
            stall_cnt <= 16'd0;
            timeout   <= 1'b1;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end

        S_CMP: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= CHECK_TS ? (ts_value == EXPECTED_TS) : 1'b1;
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          if (start) begin
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            stall_cnt <= 16'd0;
            state     <= S_RD_ID;
`ifdef SYSID_CHECKER_RECHECK_EN
            recheck_cnt <= 32'd0;
          end else if (!timeout) begin
            // Background re-run keeps done and the old flags visible until CMP.
            if (recheck_cnt == RECHECK_LAST) begin
              recheck_cnt <= 32'd0;
              stall_cnt   <= 16'd0;
              state       <= S_RD_ID;
            end else begin
              recheck_cnt <= recheck_cnt + 32'd1;
            end
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] id_value, ts_value;
  logic        busy, done, id_ok, ts_ok, timeout;

  // second instance with the timestamp check disabled
  logic        b_address, b_read;
  logic [31:0] b_id_value, b_ts_value;
  logic        b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;

  // slave model controls
  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = 32'd1458169385;
  int          stall_n = 0;
  logic        stuck   = 1'b0;
  int          wcnt    = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sysid_checker #(.TIMEOUT_CYCLES(8), .RECHECK_PERIOD(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .id_value(id_value), .ts_value(ts_value), .busy(busy), .done(done),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout));

  sysid_checker #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(8), .RECHECK_PERIOD(16)) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(b_address), .avm_read(b_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .id_value(b_id_value), .ts_value(b_ts_value), .busy(b_busy), .done(b_done),
    .id_ok(b_id_ok), .ts_ok(b_ts_ok), .timeout(b_timeout));

  // sysid slave: word select on address, optional fixed stall per read
  assign avm_readdata    = avm_address ? ts_word : id_word;
  assign avm_waitrequest = stuck || (avm_read && (wcnt < stall_n));

  always @(posedge clock) begin
    if (avm_read && !avm_waitrequest) wcnt <= 0;
    else if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle on the falling edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_read", {31'd0, avm_read}, 0);
    chk("rst_addr", {31'd0, avm_address}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 0);
    chk("rst_id_value", id_value, 0);
    @(negedge clock);
    reset = 1'b0;

    // 1: no stalls, matching words -> done at edge 4
    step();
    chk("t1_e1_read", {31'd0, avm_read}, 1);
    chk("t1_e1_addr", {31'd0, avm_address}, 0);
    chk("t1_e1_busy", {31'd0, busy}, 1);
    step();
    chk("t1_e2_addr", {31'd0, avm_address}, 1);
    step();
    chk("t1_e3_read", {31'd0, avm_read}, 0);
    chk("t1_e3_done", {31'd0, done}, 0);
    chk("t1_e3_busy", {31'd0, busy}, 1);
    step();
    chk("t1_e4_done", {31'd0, done}, 1);
    chk("t1_e4_busy", {31'd0, busy}, 0);
    chk("t1_e4_flags", {29'd0, id_ok, ts_ok, timeout}, 3'b110);
    chk("t1_ts_value", ts_value, 32'd1458169385);

    // start ignored while the check is running is not exercised here;
    // 2: bad timestamp
    ts_word = 32'h12345678;
    pulse_start();
    chk("t2_start_done_clr", {31'd0, done}, 0);
    chk("t2_start_ok_clr", {31'd0, id_ok}, 0);
    step(); step(); step();
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_id_ok", {31'd0, id_ok}, 1);
    chk("t2_ts_ok", {31'd0, ts_ok}, 0);
    chk("t2_ts_value", ts_value, 32'h12345678);
    chk("t2_nots_ts_ok", {31'd0, b_ts_ok}, 1);
    chk("t2_nots_ts_value", b_ts_value, 32'h12345678);

    // 3: three stall cycles per read, via a fresh reset
    ts_word = 32'd1458169385;
    stall_n = 3;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("t3_e%0d_rd_id", e), {30'd0, avm_read, avm_address}, 2'b10);
    end
    for (int e = 5; e <= 8; e++) begin
      step();
      chk($sformatf("t3_e%0d_rd_ts", e), {30'd0, avm_read, avm_address}, 2'b11);
    end
    step();
    chk("t3_e9_done", {31'd0, done}, 0);
    step();
    chk("t3_e10_done", {31'd0, done}, 1);
    chk("t3_flags", {29'd0, id_ok, ts_ok, timeout}, 3'b110);
    chk("t3_ts_value", ts_value, 32'd1458169385);
    stall_n = 0;

    // 4: waitrequest stuck -> timeout after 8 tolerated stall cycles
    stuck = 1'b1;
    id_word = 32'hDEADBEEF;
    pulse_start();
    for (int e = 1; e <= 8; e++) step();
    chk("t4_pre_timeout", {31'd0, timeout}, 0);
    chk("t4_pre_busy", {31'd0, busy}, 1);
    step();
    chk("t4_timeout", {31'd0, timeout}, 1);
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_oks", {30'd0, id_ok, ts_ok}, 0);
    chk("t4_id_kept", id_value, 32'd0);
    chk("t4_read_drop", {31'd0, avm_read}, 0);
    stuck = 1'b0;
    id_word = 32'd0;
    pulse_start();
    chk("t4_timeout_clr", {31'd0, timeout}, 0);
    step(); step(); step();
    chk("t4_retry_done", {31'd0, done}, 1);
    chk("t4_retry_flags", {29'd0, id_ok, ts_ok, timeout}, 3'b110);

    // 5: asynchronous reset in RD_TS
    id_word = 32'hA5A5A5A5;
    pulse_start();
    step();
    chk("t5_in_rd_ts", {30'd0, avm_read, avm_address}, 2'b11);
    chk("t5_id_cap", id_value, 32'hA5A5A5A5);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_read", {31'd0, avm_read}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_id_value", id_value, 0);
    chk("t5_rst_ts_value", ts_value, 0);
    id_word = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    step(); step(); step();
    chk("t5_e3_done", {31'd0, done}, 0);
    step();
    chk("t5_e4_done", {31'd0, done}, 1);
    chk("t5_flags", {29'd0, id_ok, ts_ok, timeout}, 3'b110);

`ifdef SYSID_CHECKER_RECHECK_EN
    // 6: background re-run 16 cycles after done
    ts_word = 32'h0BAD0BAD;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk($sformatf("t6_wait%0d", e), {30'd0, busy, done}, 2'b01);
    end
    step();
    chk("t6_rerun_start", {29'd0, busy, done, avm_read}, 3'b111);
    step(); step();
    chk("t6_cmp_old_ts_ok", {29'd0, busy, done, ts_ok}, 3'b111);
    step();
    chk("t6_new_flags", {28'd0, busy, done, id_ok, ts_ok}, 4'b0110);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
